ddr_cmd_scheduler: RTL and testbench
====================================

Name: ddr_cmd_scheduler

Overview:
- Parametrised successor to the single-request DDR5 command sequencer.
- Buffers CPU requests (read / write / ifetch) in a configurable-depth in-order queue and decodes each address into channel, bank group, bank, row and column.
- Emits two-cycle DDR5 command pairs (ACT, RD, WR, PRE) under tRCD/tCAS/tCWL/tBURST/tWR/tRP constraints.
- Adds a selectable open-page policy: a per-bank open-row table lets row hits skip ACT.
- Sits between the trace/CPU request interface and the DIMM command bus.

Parameters:
- QUEUE_DEPTH, 16, request queue entries (power of 2, ≥2)
- ADDR_W, 36, request address width
- PAGE_POLICY, 0, 0 = close-page (PRE after every CAS), 1 = open-page
- T_RCD, 39, min cycles ACT0→CAS0
- T_CAS, 40, read latency used for RD0→PRE0
- T_CWL, 38, write latency
- T_BURST, 8, burst cycles; also min CAS0→CAS0 spacing
- T_WR, 72, write recovery
- T_RP, 39, min cycles PRE0→ACT0
- CNT_W, 8, width of saturating timing counters (must hold T_CWL+T_BURST+T_WR)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  queue not full
- req_op  in  2  0 = read, 1 = write, 2 = ifetch (read), 3 = illegal
- req_addr  in  ADDR_W  physical address
- cmd_valid  out  1  command cycle valid
- cmd_type  out  2  0 = ACT, 1 = RD, 2 = WR, 3 = PRE
- cmd_phase  out  1  0 = first half, 1 = second half of a two-cycle command
- cmd_channel  out  1  addr[6]
- cmd_bg  out  3  addr[9:7]
- cmd_bank  out  2  addr[11:10]
- cmd_row  out  16  addr[33:18]; valid for ACT, else 0
- cmd_col  out  10  {addr[17:12], addr[5:2]}; valid for RD/WR, else 0
- q_count  out  $clog2(QUEUE_DEPTH)+1  occupancy
- q_full  out  1  occupancy == QUEUE_DEPTH
- q_empty  out  1  occupancy == 0
- err_op  out  1  one-cycle pulse: illegal op dropped

Behaviour:
- Reset values (asynchronous, immediate): all cmd_* = 0, q_count = 0, q_empty = 1, q_full = 0, err_op = 0, req_ready = 1. Bank table invalidated. Timing counters set to saturated (all constraints met). FSM to IDLE. In-flight command pairs are abandoned, not completed.
- Enqueue: push on req_valid && req_ready at a clk edge. req_ready = !q_full; no push-when-full even if a pop occurs in the same cycle. req_op == 3: not stored, err_op pulses the next cycle, q_count unchanged.
- Decode: the head entry is latched into the FSM when it leaves IDLE. Bank index = {channel, bg, bank} (64 entries).
- Counters cyc_act, cyc_cas, cyc_pre:
  - Cleared to 1 on the edge that issues phase 0 of their command type.
  - Otherwise increment, saturating at 2^CNT_W−1.
  - last_cas_wr records whether the latest CAS was a write.
- Issue gates:
  - ACT0 requires cyc_pre ≥ T_RP.
  - CAS0 requires cyc_act ≥ T_RCD and cyc_cas ≥ T_BURST.
  - PRE0 requires cyc_cas ≥ T_CAS+T_BURST (read) or T_CWL+T_BURST+T_WR (write).
- FSM states: IDLE, PRE0, PRE1, ACT0, ACT1, CAS0, CAS1, APRE0, APRE1. Each *0 state holds until its gate is met, then drives phase 0. The *1 state always follows next cycle with phase 1 and identical fields.
- IDLE transitions (queue non-empty):
  - Open-page, bank open with matching row → CAS0.
  - Open-page, bank open with different row → PRE0.
  - Otherwise → ACT0.
- Fixed sequences: PRE1→ACT0, ACT1→CAS0.
- CAS1 and retirement: CAS1 pops the head on its edge. Then:
  - close-page → APRE0 (precharge of the same bank, using latched fields);
  - open-page → IDLE.
  - APRE1 → IDLE.
- Bank table updates: ACT0 sets open[b] and row[b]. PRE0/APRE0 clears open[b].
- Latency: the first command (phase 0) is on the outputs 2 cycles after the enqueue edge when the queue and FSM are idle and gates are met.
- Commands are registered; cmd_valid is 0 whenever the FSM waits on a gate or is IDLE.
- Simultaneous push and pop: q_count unchanged. A push into an empty queue is not visible to IDLE until the next cycle.

Test Plan:
- Close-page: read 0x000000000 accepted at edge 0 → ACT0 at cycle 2, ACT1 at 3, RD0 at 41, RD1 at 42, PRE0 at 89, PRE1 at 90; q_count returns to 0 after edge 42.
- Close-page: write to 0x0_0004_0780 → ACT row 0x0001, bg 7, bank 1; WR0 at ACT0+39; PRE0 at WR0+118.
- Open-page row hit: two reads to the same row, column 0 and 0x3C → one ACT, RD0 at 41 and at 49; no PRE.
- Open-page conflict: read row 0x0001 then row 0x0002 in the same bank → PRE0 at first RD0+48, ACT0 at PRE0+39, RD0 at ACT0+39.
- Backpressure: 17 pushes with the FSM blocked → q_full = 1, req_ready = 0, 17th not accepted. Illegal op 3 → err_op pulse, q_count unchanged.
- Reset asserted during ACT1 → cmd_valid = 0 immediately. After release, a hit-pattern read issues ACT (table was cleared).

Source files
------------

// File: rtl/ddr_cmd_scheduler.sv
`timescale 1ns/1ps
// Queued DDR5 command scheduler: buffers CPU requests in order and emits two-cycle
// ACT/RD/WR/PRE pairs under DRAM timing, with optional open-page row-hit bypass.
module ddr_cmd_scheduler #(
   parameter int QUEUE_DEPTH = 16,
   parameter int ADDR_W      = 36,
   parameter int PAGE_POLICY = 0,
   parameter int T_RCD       = 39,
   parameter int T_CAS       = 40,
   parameter int T_CWL       = 38,
   parameter int T_BURST     = 8,
   parameter int T_WR        = 72,
   parameter int T_RP        = 39,
   parameter int CNT_W       = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req_valid,
   output logic                            req_ready,
   input  logic [1:0]                      req_op,
   input  logic [ADDR_W-1:0]               req_addr,
   output logic                            cmd_valid,
   output logic [1:0]                      cmd_type,
   output logic                            cmd_phase,
   output logic                            cmd_channel,
   output logic [2:0]                      cmd_bg,
   output logic [1:0]                      cmd_bank,
   output logic [15:0]                     cmd_row,
   output logic [9:0]                      cmd_col,
   output logic [$clog2(QUEUE_DEPTH):0]    q_count,
   output logic                            q_full,
   output logic                            q_empty,
   output logic                            err_op
);
   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int QC_W  = PTR_W + 1;
   localparam int ENT_W = 33;
   localparam logic [CNT_W-1:0] RP_C     = CNT_W'(T_RP);
   localparam logic [CNT_W-1:0] RCD_C    = CNT_W'(T_RCD);
   localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(T_BURST);
   localparam logic [CNT_W-1:0] RD_PRE_C = CNT_W'(T_CAS + T_BURST);
   localparam logic [CNT_W-1:0] WR_PRE_C = CNT_W'(T_CWL + T_BURST + T_WR);
   localparam logic [1:0] C_ACT = 2'd0, C_RD = 2'd1, C_WR = 2'd2, C_PRE = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE, S_PRE0, S_PRE1, S_ACT0, S_ACT1, S_CAS0, S_CAS1, S_APRE0, S_APRE1
   } state_t;

   state_t                 state_q;
   logic [ENT_W-1:0]       mem_q [QUEUE_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
   logic [QC_W-1:0]        count_q, count_d;
   logic                   err_q, push, pop;
   logic [ENT_W-1:0]       req_ent, head_ent, lat_q;
   logic [5:0]             head_idx, lat_idx;
   logic                   head_open, head_row_match;
   logic [63:0]            open_q;
   logic [15:0]            row_tbl [64];
   logic [CNT_W-1:0]       cyc_act_q, cyc_cas_q, cyc_pre_q;
   logic                   last_cas_wr_q;
   logic                   act_ok, cas_ok, pre_ok;
   logic                   issue_v, issue_p, issue_act, issue_cas, issue_pre;
   logic [1:0]             issue_t;
   logic                   cmd_valid_q, cmd_phase_q, cmd_ch_q;
   logic [1:0]             cmd_type_q, cmd_bank_q;
   logic [2:0]             cmd_bg_q;
   logic [15:0]            cmd_row_q;
   logic [9:0]             cmd_col_q;
   logic                   unused_addr;

   // Entry layout: {is_write, channel, bg[2:0], bank[1:0], row[15:0], col[9:0]}
   assign req_ent     = {req_op == 2'd1, req_addr[6], req_addr[9:7], req_addr[11:10],
                         req_addr[33:18], req_addr[17:12], req_addr[5:2]};
   assign unused_addr = ^{req_addr[1:0], req_addr[ADDR_W-1:34]};

   assign q_full    = (count_q == QC_W'(QUEUE_DEPTH));
   assign q_empty   = (count_q == '0);
   assign q_count   = count_q;
   assign req_ready = !q_full;
   assign err_op    = err_q;
   assign push      = req_valid && req_ready && (req_op != 2'd3);
   assign pop       = (state_q == S_CAS1);

   always_comb begin
      count_d = count_q;
      if (push && !pop)
         count_d = count_q + 1'b1;
      else if (pop && !push)
         count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         err_q   <= req_valid && req_ready && (req_op == 2'd3);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= req_ent;
   end

   assign head_ent       = mem_q[rd_ptr_q];
   assign head_idx       = head_ent[31:26];
   assign lat_idx        = lat_q[31:26];
   assign head_open      = open_q[head_idx];
   assign head_row_match = (row_tbl[head_idx] == head_ent[25:10]);

   assign act_ok = (cyc_pre_q >= RP_C);
   assign cas_ok = (cyc_act_q >= RCD_C) && (cyc_cas_q >= BURST_C);
   assign pre_ok = (cyc_cas_q >= (last_cas_wr_q ? WR_PRE_C : RD_PRE_C));

   always_comb begin
      issue_v = 1'b0;
      issue_p = 1'b0;
      issue_t = C_ACT;
      case (state_q)
         S_PRE0, S_APRE0: begin issue_v = pre_ok; issue_t = C_PRE; end
         S_PRE1, S_APRE1: begin issue_v = 1'b1; issue_p = 1'b1; issue_t = C_PRE; end
         S_ACT0:          begin issue_v = act_ok; issue_t = C_ACT; end
         S_ACT1:          begin issue_v = 1'b1; issue_p = 1'b1; issue_t = C_ACT; end
         S_CAS0:          begin issue_v = cas_ok; issue_t = lat_q[32] ? C_WR : C_RD; end
         S_CAS1:          begin issue_v = 1'b1; issue_p = 1'b1; issue_t = lat_q[32] ? C_WR : C_RD; end
         default:         issue_v = 1'b0;
      endcase
   end

   assign issue_act = issue_v && !issue_p && (issue_t == C_ACT);
   assign issue_cas = issue_v && !issue_p && ((issue_t == C_RD) || (issue_t == C_WR));
   assign issue_pre = issue_v && !issue_p && (issue_t == C_PRE);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   // Counters restart at 1 on the issuing edge so "value >= T" means T cycles elapsed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_act_q     <= '1;
         cyc_cas_q     <= '1;
         cyc_pre_q     <= '1;
         last_cas_wr_q <= 1'b0;
      end else begin
         cyc_act_q <= issue_act ? CNT_W'(1) : sat_inc(cyc_act_q);
         cyc_cas_q <= issue_cas ? CNT_W'(1) : sat_inc(cyc_cas_q);
         cyc_pre_q <= issue_pre ? CNT_W'(1) : sat_inc(cyc_pre_q);
         if (issue_cas) last_cas_wr_q <= lat_q[32];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open_q <= '0;
      end else begin
         if (issue_act) open_q[lat_idx] <= 1'b1;
         if (issue_pre) open_q[lat_idx] <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (issue_act) row_tbl[lat_idx] <= lat_q[25:10];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         lat_q       <= '0;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= 2'd0;
         cmd_phase_q <= 1'b0;
         cmd_ch_q    <= 1'b0;
         cmd_bg_q    <= 3'd0;
         cmd_bank_q  <= 2'd0;
         cmd_row_q   <= 16'd0;
         cmd_col_q   <= 10'd0;
      end else begin
         cmd_valid_q <= issue_v;
         cmd_type_q  <= issue_v ? issue_t : 2'd0;
         cmd_phase_q <= issue_p;
         cmd_ch_q    <= issue_v ? lat_q[31] : 1'b0;
         cmd_bg_q    <= issue_v ? lat_q[30:28] : 3'd0;
         cmd_bank_q  <= issue_v ? lat_q[27:26] : 2'd0;
         cmd_row_q   <= (issue_v && issue_t == C_ACT) ? lat_q[25:10] : 16'd0;
         cmd_col_q   <= (issue_v && (issue_t == C_RD || issue_t == C_WR)) ? lat_q[9:0] : 10'd0;
         case (state_q)
            S_IDLE: begin
               if (!q_empty) begin
                  lat_q <= head_ent;
                  if (PAGE_POLICY != 0 && head_open)
                     state_q <= head_row_match ? S_CAS0 : S_PRE0;
                  else
                     state_q <= S_ACT0;
               end
            end
            S_PRE0:  if (issue_v) state_q <= S_PRE1;
            S_PRE1:  state_q <= S_ACT0;
            S_ACT0:  if (issue_v) state_q <= S_ACT1;
            S_ACT1:  state_q <= S_CAS0;
            S_CAS0:  if (issue_v) state_q <= S_CAS1;
            S_CAS1:  state_q <= (PAGE_POLICY != 0) ? S_IDLE : S_APRE0;
            S_APRE0: if (issue_v) state_q <= S_APRE1;
            S_APRE1: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_type    = cmd_type_q;
   assign cmd_phase   = cmd_phase_q;
   assign cmd_channel = cmd_ch_q;
   assign cmd_bg      = cmd_bg_q;
   assign cmd_bank    = cmd_bank_q;
   assign cmd_row     = cmd_row_q;
   assign cmd_col     = cmd_col_q;
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
`timescale 1ns/1ps
// Directed bench: one close-page and one open-page scheduler, checking command
// timing and fields against hand-computed cycle offsets.
module tb_ddr_cmd_scheduler;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   logic        c_req_valid, c_req_ready, c_cmd_valid, c_cmd_phase, c_cmd_channel;
   logic [1:0]  c_req_op, c_cmd_type, c_cmd_bank;
   logic [35:0] c_req_addr;
   logic [2:0]  c_cmd_bg;
   logic [15:0] c_cmd_row;
   logic [9:0]  c_cmd_col;
   logic [4:0]  c_q_count;
   logic        c_q_full, c_q_empty, c_err_op;

   logic        o_req_valid, o_req_ready, o_cmd_valid, o_cmd_phase, o_cmd_channel;
   logic [1:0]  o_req_op, o_cmd_type, o_cmd_bank;
   logic [35:0] o_req_addr;
   logic [2:0]  o_cmd_bg;
   logic [15:0] o_cmd_row;
   logic [9:0]  o_cmd_col;
   logic [4:0]  o_q_count;
   logic        o_q_full, o_q_empty, o_err_op;

   ddr_cmd_scheduler #(.PAGE_POLICY(0)) u_close (
      .clk(clk), .rst(rst), .req_valid(c_req_valid), .req_ready(c_req_ready),
      .req_op(c_req_op), .req_addr(c_req_addr), .cmd_valid(c_cmd_valid),
      .cmd_type(c_cmd_type), .cmd_phase(c_cmd_phase), .cmd_channel(c_cmd_channel),
      .cmd_bg(c_cmd_bg), .cmd_bank(c_cmd_bank), .cmd_row(c_cmd_row), .cmd_col(c_cmd_col),
      .q_count(c_q_count), .q_full(c_q_full), .q_empty(c_q_empty), .err_op(c_err_op));

   ddr_cmd_scheduler #(.PAGE_POLICY(1)) u_open (
      .clk(clk), .rst(rst), .req_valid(o_req_valid), .req_ready(o_req_ready),
      .req_op(o_req_op), .req_addr(o_req_addr), .cmd_valid(o_cmd_valid),
      .cmd_type(o_cmd_type), .cmd_phase(o_cmd_phase), .cmd_channel(o_cmd_channel),
      .cmd_bg(o_cmd_bg), .cmd_bank(o_cmd_bank), .cmd_row(o_cmd_row), .cmd_col(o_cmd_col),
      .q_count(o_q_count), .q_full(o_q_full), .q_empty(o_q_empty), .err_op(o_err_op));

   typedef struct packed {
      logic [31:0] t;
      logic [1:0]  typ;
      logic        ph;
      logic        ch;
      logic [2:0]  bg;
      logic [1:0]  bank;
      logic [15:0] row;
      logic [9:0]  col;
   } ev_t;

   ev_t c_ev, o_ev;
   assign c_ev = {edge_cnt, c_cmd_type, c_cmd_phase, c_cmd_channel, c_cmd_bg, c_cmd_bank, c_cmd_row, c_cmd_col};
   assign o_ev = {edge_cnt, o_cmd_type, o_cmd_phase, o_cmd_channel, o_cmd_bg, o_cmd_bank, o_cmd_row, o_cmd_col};

   localparam logic [1:0] ACT = 2'd0, RD = 2'd1, WR = 2'd2, PRE = 2'd3;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input bit sel, input logic [1:0] op, input logic [35:0] addr,
                       output int e, output bit acc);
      @(negedge clk);
      if (sel) begin
         o_req_valid = 1'b1; o_req_op = op; o_req_addr = addr; acc = o_req_ready;
      end else begin
         c_req_valid = 1'b1; c_req_op = op; c_req_addr = addr; acc = c_req_ready;
      end
      @(posedge clk);
      #1;
      e = edge_cnt;
      o_req_valid = 1'b0;
      c_req_valid = 1'b0;
      $display("push sel=%0d op=%0d addr=0x%09h accepted=%0d edge=%0d", sel, op, addr, acc, e);
   endtask

   task automatic next_cmd(input bit sel, input int budget, output bit found, output ev_t ev);
      found = 1'b0;
      ev    = '0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (sel ? o_cmd_valid : c_cmd_valid) begin
            ev    = sel ? o_ev : c_ev;
            found = 1'b1;
            break;
         end
      end
      if (found)
         $display("cmd sel=%0d edge=%0d type=%0d ph=%0d ch=%0d bg=%0d bank=%0d row=0x%0h col=0x%0h",
                  sel, ev.t, ev.typ, ev.ph, ev.ch, ev.bg, ev.bank, ev.row, ev.col);
   endtask

   task automatic expect_cmd(input bit sel, input string tag, input logic [1:0] typ,
                             input logic ph, output ev_t ev);
      bit found;
      next_cmd(sel, 300, found, ev);
      check_val({tag, "_seen"}, 32'(found), 32'd1);
      if (found) begin
         check_val({tag, "_type"}, 32'(ev.typ), 32'(typ));
         check_val({tag, "_phase"}, 32'(ev.ph), 32'(ph));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  e, e2;
      bit  acc, found;
      int  acc_cnt;
      ev_t a, a2, r, r2, w, p, x;

      rst = 1'b1;
      c_req_valid = 0; c_req_op = 0; c_req_addr = '0;
      o_req_valid = 0; o_req_op = 0; o_req_addr = '0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_cmd_valid", 32'(c_cmd_valid), 32'd0);
      check_val("rst_q_count", 32'(c_q_count), 32'd0);
      check_val("rst_q_empty", 32'(c_q_empty), 32'd1);
      check_val("rst_q_full", 32'(c_q_full), 32'd0);
      check_val("rst_req_ready", 32'(c_req_ready), 32'd1);
      check_val("rst_err_op", 32'(c_err_op), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // close-page read at address 0
      push(0, 2'd0, 36'h0, e, acc);
      check_val("t1_accept", 32'(acc), 32'd1);
      check_val("t1_qcount_push", 32'(c_q_count), 32'd1);
      expect_cmd(0, "t1_act0", ACT, 1'b0, a);
      check_val("t1_act0_time", a.t - e, 32'd2);
      expect_cmd(0, "t1_act1", ACT, 1'b1, x);
      check_val("t1_act1_time", x.t - e, 32'd3);
      expect_cmd(0, "t1_rd0", RD, 1'b0, r);
      check_val("t1_rd0_time", r.t - e, 32'd41);
      expect_cmd(0, "t1_rd1", RD, 1'b1, x);
      check_val("t1_rd1_time", x.t - e, 32'd42);
      check_val("t1_qcount_pop", 32'(c_q_count), 32'd0);
      expect_cmd(0, "t1_pre0", PRE, 1'b0, p);
      check_val("t1_pre0_time", p.t - e, 32'd89);
      expect_cmd(0, "t1_pre1", PRE, 1'b1, x);
      check_val("t1_pre1_time", x.t - e, 32'd90);

      // close-page write: row 1, bg 7, bank 1
      push(0, 2'd1, 36'h0_0004_0780, e, acc);
      expect_cmd(0, "t2_act0", ACT, 1'b0, a);
      check_val("t2_act_row", 32'(a.row), 32'h1);
      check_val("t2_act_bg", 32'(a.bg), 32'd7);
      check_val("t2_act_bank", 32'(a.bank), 32'd1);
      expect_cmd(0, "t2_act1", ACT, 1'b1, x);
      check_val("t2_act1_row", 32'(x.row), 32'h1);
      expect_cmd(0, "t2_wr0", WR, 1'b0, w);
      check_val("t2_wr0_delay", w.t - a.t, 32'd39);
      check_val("t2_wr0_row", 32'(w.row), 32'd0);
      expect_cmd(0, "t2_wr1", WR, 1'b1, x);
      expect_cmd(0, "t2_pre0", PRE, 1'b0, p);
      check_val("t2_pre0_delay", p.t - w.t, 32'd118);
      check_val("t2_pre0_bg", 32'(p.bg), 32'd7);
      check_val("t2_pre0_bank", 32'(p.bank), 32'd1);
      expect_cmd(0, "t2_pre1", PRE, 1'b1, x);

      // illegal op is dropped with a one-cycle error pulse
      push(0, 2'd3, 36'h0_0000_1234, e, acc);
      check_val("t3_err_pulse", 32'(c_err_op), 32'd1);
      check_val("t3_qcount", 32'(c_q_count), 32'd0);
      @(posedge clk);
      #1;
      check_val("t3_err_clear", 32'(c_err_op), 32'd0);
      check_val("t3_no_cmd_state", 32'(c_q_empty), 32'd1);

      // backpressure: 17 pushes while the head is still waiting on timing
      acc_cnt = 0;
      for (int i = 0; i < 17; i++) begin
         push(0, 2'd0, 36'(i) << 18, e, acc);
         if (acc) acc_cnt++;
      end
      check_val("t4_accepted", 32'(acc_cnt), 32'd16);
      check_val("t4_last_accept", 32'(acc), 32'd0);
      check_val("t4_q_full", 32'(c_q_full), 32'd1);
      check_val("t4_req_ready", 32'(c_req_ready), 32'd0);
      check_val("t4_q_count", 32'(c_q_count), 32'd16);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_val("t4_rst_q_count", 32'(c_q_count), 32'd0);
      check_val("t4_rst_req_ready", 32'(c_req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // open-page row hit: two reads, same row
      push(1, 2'd0, 36'h0, e, acc);
      push(1, 2'd0, 36'h0_0000_3030, e2, acc);
      expect_cmd(1, "t5_act0", ACT, 1'b0, a);
      check_val("t5_act0_time", a.t - e, 32'd2);
      expect_cmd(1, "t5_act1", ACT, 1'b1, x);
      expect_cmd(1, "t5_rd0a", RD, 1'b0, r);
      check_val("t5_rd0a_time", r.t - e, 32'd41);
      expect_cmd(1, "t5_rd1a", RD, 1'b1, x);
      expect_cmd(1, "t5_rd0b", RD, 1'b0, r2);
      check_val("t5_rd0b_time", r2.t - e, 32'd49);
      check_val("t5_rd0b_col", 32'(r2.col), 32'h3c);
      expect_cmd(1, "t5_rd1b", RD, 1'b1, x);
      check_val("t5_qcount", 32'(o_q_count), 32'd0);
      next_cmd(1, 80, found, x);
      check_val("t5_no_pre", 32'(found), 32'd0);

      // open-page conflict on channel 1: row 1 then row 2
      push(1, 2'd0, 36'h0_0004_0040, e, acc);
      push(1, 2'd0, 36'h0_0008_0040, e2, acc);
      expect_cmd(1, "t6_act0a", ACT, 1'b0, a);
      check_val("t6_act0a_row", 32'(a.row), 32'h1);
      check_val("t6_act0a_ch", 32'(a.ch), 32'd1);
      expect_cmd(1, "t6_act1a", ACT, 1'b1, x);
      expect_cmd(1, "t6_rd0a", RD, 1'b0, r);
      check_val("t6_rd0a_delay", r.t - a.t, 32'd39);
      expect_cmd(1, "t6_rd1a", RD, 1'b1, x);
      expect_cmd(1, "t6_pre0", PRE, 1'b0, p);
      check_val("t6_pre0_delay", p.t - r.t, 32'd48);
      check_val("t6_pre0_ch", 32'(p.ch), 32'd1);
      expect_cmd(1, "t6_pre1", PRE, 1'b1, x);
      expect_cmd(1, "t6_act0b", ACT, 1'b0, a2);
      check_val("t6_act0b_delay", a2.t - p.t, 32'd39);
      check_val("t6_act0b_row", 32'(a2.row), 32'h2);
      expect_cmd(1, "t6_act1b", ACT, 1'b1, x);
      expect_cmd(1, "t6_rd0b", RD, 1'b0, r2);
      check_val("t6_rd0b_delay", r2.t - a2.t, 32'd39);
      expect_cmd(1, "t6_rd1b", RD, 1'b1, x);

      // reset during ACT1, then a would-be hit must re-activate
      push(1, 2'd0, 36'h0_000C_0040, e, acc);
      expect_cmd(1, "t7_pre0", PRE, 1'b0, x);
      expect_cmd(1, "t7_pre1", PRE, 1'b1, x);
      expect_cmd(1, "t7_act0", ACT, 1'b0, a);
      check_val("t7_act0_row", 32'(a.row), 32'h3);
      @(posedge clk);
      #1;
      check_val("t7_in_act1", 32'({o_cmd_valid, o_cmd_phase}), 32'd3);
      rst = 1'b1;
      #1;
      check_val("t7_rst_cmd_valid", 32'(o_cmd_valid), 32'd0);
      check_val("t7_rst_q_count", 32'(o_q_count), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(1, 2'd0, 36'h0_000C_0040, e, acc);
      expect_cmd(1, "t7_post_act0", ACT, 1'b0, a);
      check_val("t7_post_act0_time", a.t - e, 32'd2);
      check_val("t7_post_act0_row", 32'(a.row), 32'h3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
